// File: rtl/query_page_scheduler.sv
// Per-query sequencer: holds the column projector configuration for one query and drains the
// projector result FIFO into page bursts, issuing one page-write command after each page.
module query_page_scheduler #(
  parameter int PAGE_WORDS = 128,
  parameter int PAGE_BYTES = 4096
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [31:0]  cmd_base_addr,
  input  logic [31:0]  cmd_record_num,
  input  logic [7:0]   cmd_column_flag,
  output logic         cfg_valid,
  output logic [31:0]  cfg_record_num,
  output logic [7:0]   cfg_column_flag,
  input  logic         proj_done,
  input  logic         data_fifo_empty,
  output logic         data_fifo_rd_en,
  input  logic [255:0] data_fifo_dout,
  output logic         page_wr_valid,
  input  logic         page_wr_ready,
  output logic [255:0] page_wr_data,
  output logic         wcmd_valid,
  input  logic         wcmd_ready,
  output logic [127:0] wcmd,
  output logic         query_done,
  output logic [31:0]  pages_written,
  output logic         err_partial
);

  typedef enum logic [1:0] {IDLE, STREAM, ISSUE, DONE} state_e;

  localparam logic [15:0] LastWord = 16'(PAGE_WORDS - 1);
  localparam logic [15:0] PageLen  = 16'(PAGE_WORDS);
  localparam logic [31:0] PageInc  = 32'(PAGE_BYTES);

  state_e         state_q;
  logic [31:0]    pageAddr_q;
  logic [15:0]    wordCnt_q;
  logic [15:0]    length_q;
  logic           doneSeen_q;
  logic           cfgValid_q;
  logic [31:0]    cfgRecordNum_q;
  logic [7:0]     cfgColumnFlag_q;
  logic           pwValid_q;
  logic [255:0]   pwData_q;
  logic [31:0]    pagesWritten_q;
  logic           errPartial_q;

  logic wordAccept;
  logic lastAccept;
  logic fifoPop;
  logic drained;

  // The accept that closes a page must not pull the first word of the next page into the register.
  assign wordAccept = pwValid_q & page_wr_ready;
  assign lastAccept = wordAccept & (wordCnt_q == LastWord);
  assign fifoPop    = (state_q == STREAM) & ~data_fifo_empty & (~pwValid_q | page_wr_ready) & ~lastAccept;
  assign drained    = doneSeen_q & data_fifo_empty & ~pwValid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      pageAddr_q      <= '0;
      wordCnt_q       <= '0;
      length_q        <= '0;
      doneSeen_q      <= 1'b0;
      cfgValid_q      <= 1'b0;
      cfgRecordNum_q  <= '0;
      cfgColumnFlag_q <= '0;
      pwValid_q       <= 1'b0;
      pwData_q        <= '0;
      pagesWritten_q  <= '0;
      errPartial_q    <= 1'b0;
    end else begin
      if (state_q != IDLE && proj_done) doneSeen_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            cfgRecordNum_q  <= cmd_record_num;
            cfgColumnFlag_q <= cmd_column_flag;
            cfgValid_q      <= 1'b1;
            pageAddr_q      <= cmd_base_addr;
            wordCnt_q       <= '0;
            doneSeen_q      <= 1'b0;
            pagesWritten_q  <= '0;
            errPartial_q    <= 1'b0;
            state_q         <= STREAM;
          end
        end
        STREAM: begin
          if (fifoPop) begin
            pwValid_q <= 1'b1;
            pwData_q  <= data_fifo_dout;
          end else if (wordAccept) begin
            pwValid_q <= 1'b0;
          end
          if (wordAccept) wordCnt_q <= wordCnt_q + 16'd1;
          if (lastAccept) begin
            length_q <= PageLen;
            state_q  <= ISSUE;
          end else if (drained) begin
            // A short final page still gets a command, flagged as partial.
            if (wordCnt_q == 16'd0) begin
              state_q <= DONE;
            end else begin
              length_q     <= wordCnt_q;
              errPartial_q <= 1'b1;
              state_q      <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (wcmd_ready) begin
            pageAddr_q     <= pageAddr_q + PageInc;
            pagesWritten_q <= pagesWritten_q + 32'd1;
            wordCnt_q      <= '0;
            state_q        <= drained ? DONE : STREAM;
          end
        end
        DONE: begin
          cfgValid_q <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready       = (state_q == IDLE);
  assign cfg_valid       = cfgValid_q;
  assign cfg_record_num  = cfgRecordNum_q;
  assign cfg_column_flag = cfgColumnFlag_q;
  assign data_fifo_rd_en = fifoPop;
  assign page_wr_valid   = pwValid_q;
  assign page_wr_data    = pwData_q;
  assign wcmd_valid      = (state_q == ISSUE);
  assign wcmd            = wcmd_valid ? {72'b0, 8'h01, length_q, pageAddr_q} : 128'b0;
  assign query_done      = (state_q == DONE);
  assign pages_written   = pagesWritten_q;
  assign err_partial     = errPartial_q;

endmodule
